// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, one quotient bit per clock.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   start                 division request, accepted in IDLE or DONE
//   signed_mode           1 = two's-complement operands (captured with start)
//   dividend, divisor     operands (captured with start)
//   busy                  high while iterating (state RUN)
//   done                  one-cycle pulse when results become valid
//   quotient, remainder   results, held until the next result is registered
//   div_by_zero, overflow flags, held with the results, cleared on accept
//
// The operands are converted to magnitudes on capture; the quotient bits are
// shifted into the vacated low end of the dividend register, and sign
// correction is applied on the last iteration (truncating division, remainder
// takes the sign of the dividend).
module seq_divider #(
  parameter int N_WIDTH = 6,
  parameter int D_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [N_WIDTH-1:0] dividend,
  input  logic [D_WIDTH-1:0] divisor,
  output logic               busy,
  output logic               done,
  output logic [N_WIDTH-1:0] quotient,
  output logic [D_WIDTH-1:0] remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int CNT_W = $clog2(N_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [N_WIDTH-1:0] dvd_q;       // dividend bits out at the top, quotient bits in at the bottom
  logic [D_WIDTH-1:0] dsr_q;       // divisor magnitude
  logic [D_WIDTH-1:0] rem_q;       // partial remainder, always < divisor
  logic               neg_quo_q;
  logic               neg_rem_q;
  logic               ovf_pend_q;
  logic [N_WIDTH-1:0] quo_q;
  logic [D_WIDTH-1:0] rmd_q;
  logic               dbz_q;
  logic               ovf_q;

  logic               accept;
  logic               dvd_neg, dsr_neg, dsr_zero, ovf_cond;
  logic [N_WIDTH-1:0] dvd_mag;
  logic [D_WIDTH-1:0] dsr_mag;
  logic [D_WIDTH:0]   shifted;
  logic               qbit;
  logic [D_WIDTH-1:0] rem_nxt;
  logic [N_WIDTH-1:0] quo_nxt;
  logic [N_WIDTH-1:0] quo_fix;
  logic [D_WIDTH-1:0] rem_fix;

  assign accept   = start && (state_q != RUN);
  assign dvd_neg  = signed_mode & dividend[N_WIDTH-1];
  assign dsr_neg  = signed_mode & divisor[D_WIDTH-1];
  assign dvd_mag  = dvd_neg ? (~dividend + N_WIDTH'(1)) : dividend;
  assign dsr_mag  = dsr_neg ? (~divisor + D_WIDTH'(1)) : divisor;
  assign dsr_zero = (divisor == '0);
  assign ovf_cond = signed_mode && (dividend == {1'b1, {(N_WIDTH-1){1'b0}}}) && (&divisor);

  // Restoring step: the shifted remainder needs one extra bit before the trial subtract.
  assign shifted  = {rem_q, dvd_q[N_WIDTH-1]};
  assign qbit     = (shifted >= {1'b0, dsr_q});
  assign rem_nxt  = qbit ? D_WIDTH'(shifted - {1'b0, dsr_q}) : shifted[D_WIDTH-1:0];
  assign quo_nxt  = {dvd_q[N_WIDTH-2:0], qbit};
  assign quo_fix  = neg_quo_q ? (~quo_nxt + N_WIDTH'(1)) : quo_nxt;
  assign rem_fix  = neg_rem_q ? (~rem_nxt + D_WIDTH'(1)) : rem_nxt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = dsr_zero ? DONE : RUN;
      RUN:  if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE: begin
        if (start) state_d = dsr_zero ? DONE : RUN;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      dvd_q      <= '0;
      dsr_q      <= '0;
      rem_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      ovf_pend_q <= 1'b0;
      quo_q      <= '0;
      rmd_q      <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (accept) begin
      dbz_q <= dsr_zero;
      ovf_q <= 1'b0;
      if (dsr_zero) begin
        quo_q <= '1;
        rmd_q <= '0;
        cnt_q <= '0;
      end else begin
        dvd_q      <= dvd_mag;
        dsr_q      <= dsr_mag;
        rem_q      <= '0;
        neg_quo_q  <= dvd_neg ^ dsr_neg;
        neg_rem_q  <= dvd_neg;
        ovf_pend_q <= ovf_cond;
        cnt_q      <= CNT_W'(N_WIDTH);
      end
    end else if (state_q == RUN) begin
      dvd_q <= quo_nxt;
      rem_q <= rem_nxt;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        // Most-negative / -1 simply wraps through the magnitude path.
        quo_q <= quo_fix;
        rmd_q <= rem_fix;
        ovf_q <= ovf_pend_q;
      end
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start6, sm6;
  logic [5:0] a6;
  logic [3:0] b6;
  logic       busy6, done6, dbz6, ovf6;
  logic [5:0] q6;
  logic [3:0] r6;

  logic       start8, sm8;
  logic [7:0] a8, b8;
  logic       busy8, done8, dbz8, ovf8;
  logic [7:0] q8, r8;

  int checks = 0;
  int failures = 0;

  seq_divider #(.N_WIDTH(6), .D_WIDTH(4)) dut6 (
    .clk(clk), .rst_n(rst_n), .start(start6), .signed_mode(sm6),
    .dividend(a6), .divisor(b6), .busy(busy6), .done(done6),
    .quotient(q6), .remainder(r6), .div_by_zero(dbz6), .overflow(ovf6)
  );

  seq_divider #(.N_WIDTH(8), .D_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .dividend(a8), .divisor(b8), .busy(busy8), .done(done8),
    .quotient(q8), .remainder(r8), .div_by_zero(dbz8), .overflow(ovf8)
  );

  typedef struct {
    logic       sm;
    logic [5:0] a;
    logic [3:0] b;
    logic [5:0] q;
    logic [3:0] r;
    logic       dbz;
    logic       ovf;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge of the done cycle
  // (or after the cycle budget). lat counts edges after the capture edge.
  task automatic run6(input logic sm, input logic [5:0] a, input logic [3:0] b,
                      output int lat, output int bcnt);
    sm6 = sm; a6 = a; b6 = b; start6 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start6 = 1'b0;
    sm6 = ~sm;
    a6 = 6'($urandom);
    b6 = 4'($urandom);
    lat = 0;
    bcnt = 0;
    while (!done6 && lat < 40) begin
      if (busy6) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic chk_res(input string tag, input logic [5:0] q, input logic [3:0] r,
                         input logic dbz, input logic ovf);
    chk({tag, "_q"}, q6, q);
    chk({tag, "_r"}, r6, r);
    chk({tag, "_dbz"}, dbz6, dbz);
    chk({tag, "_ovf"}, ovf6, ovf);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bcnt, explat;

    vecs[0]  = '{1'b0, 6'd45,      4'd7,      6'd6,       4'd3,      1'b0, 1'b0};
    vecs[1]  = '{1'b0, 6'd63,      4'd1,      6'd63,      4'd0,      1'b0, 1'b0};
    vecs[2]  = '{1'b0, 6'd5,       4'd15,     6'd0,       4'd5,      1'b0, 1'b0};
    vecs[3]  = '{1'b1, 6'b100101,  4'b0101,   6'b111011,  4'b1110,   1'b0, 1'b0};
    vecs[4]  = '{1'b1, 6'b011011,  4'b1011,   6'b111011,  4'b0010,   1'b0, 1'b0};
    vecs[5]  = '{1'b1, 6'b100101,  4'b1011,   6'b000101,  4'b1110,   1'b0, 1'b0};
    vecs[6]  = '{1'b0, 6'd20,      4'd0,      6'b111111,  4'd0,      1'b1, 1'b0};
    vecs[7]  = '{1'b0, 6'd10,      4'd3,      6'd3,       4'd1,      1'b0, 1'b0};
    vecs[8]  = '{1'b1, 6'b100000,  4'b1111,   6'b100000,  4'd0,      1'b0, 1'b1};
    vecs[9]  = '{1'b1, 6'd0,       4'd0,      6'b111111,  4'd0,      1'b1, 1'b0};
    vecs[10] = '{1'b0, 6'b100101,  4'b1001,   6'd4,       4'd1,      1'b0, 1'b0};
    vecs[11] = '{1'b1, 6'b100001,  4'b0111,   6'b111100,  4'b1101,   1'b0, 1'b0};
    vecs[12] = '{1'b1, 6'b011111,  4'b1000,   6'b111101,  4'b0111,   1'b0, 1'b0};
    vecs[13] = '{1'b1, 6'b111111,  4'b1111,   6'd1,       4'd0,      1'b0, 1'b0};

    rst_n = 1'b0;
    start6 = 1'b0; sm6 = 1'b0; a6 = '0; b6 = '0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    chk("reset6", {busy6, done6, q6, r6, dbz6, ovf6}, 32'd0);
    chk("reset8", {busy8, done8, q8, r8, dbz8, ovf8}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: one vector at a time with an idle cycle between.
    for (int i = 0; i < NV; i++) begin
      explat = (vecs[i].b == 4'd0) ? 0 : 6;
      run6(vecs[i].sm, vecs[i].a, vecs[i].b, lat, bcnt);
      chk_res($sformatf("v%0d", i), vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf);
      chk($sformatf("v%0d_lat", i), lat, explat);
      chk($sformatf("v%0d_busy", i), bcnt, explat);
      @(negedge clk);
      chk($sformatf("v%0d_pulse", i), {busy6, done6}, 2'b00);
      chk($sformatf("v%0d_hold_q", i), q6, vecs[i].q);
      chk($sformatf("v%0d_hold_r", i), r6, vecs[i].r);
    end

    // Back-to-back: second start issued during the DONE cycle.
    run6(1'b0, 6'd63, 4'd1, lat, bcnt);
    chk_res("b2b_a", 6'd63, 4'd0, 1'b0, 1'b0);
    run6(1'b0, 6'd5, 4'd15, lat, bcnt);
    chk_res("b2b_b", 6'd0, 4'd5, 1'b0, 1'b0);
    chk("b2b_b_lat", lat, 6);

    // Divide by zero followed directly by a normal division clears the flag.
    run6(1'b0, 6'd20, 4'd0, lat, bcnt);
    chk_res("dz_a", 6'b111111, 4'd0, 1'b1, 1'b0);
    chk("dz_a_lat", lat, 0);
    run6(1'b0, 6'd10, 4'd3, lat, bcnt);
    chk_res("dz_b", 6'd3, 4'd1, 1'b0, 1'b0);
    chk("dz_b_lat", lat, 6);

    // Overflow flag sets, then clears on the next accepted start.
    @(negedge clk);
    run6(1'b1, 6'b100000, 4'b1111, lat, bcnt);
    chk_res("ovf_a", 6'b100000, 4'd0, 1'b0, 1'b1);
    sm6 = 1'b0; a6 = 6'd45; b6 = 4'd7; start6 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start6 = 1'b0;
    chk("ovf_clear", {busy6, ovf6, q6}, {1'b1, 1'b0, 6'b100000});
    lat = 1;
    while (!done6 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk_res("ovf_b", 6'd6, 4'd3, 1'b0, 1'b0);

    // start during RUN is ignored.
    @(negedge clk);
    sm6 = 1'b0; a6 = 6'd45; b6 = 4'd7; start6 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start6 = 1'b0;
    lat = 0;
    while (!done6 && lat < 40) begin
      if (lat == 2) begin
        start6 = 1'b1; sm6 = 1'b1; a6 = 6'd63; b6 = 4'd1;
      end else begin
        start6 = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start6 = 1'b0;
    chk_res("midrun", 6'd6, 4'd3, 1'b0, 1'b0);
    chk("midrun_lat", lat, 6);

    // Asynchronous reset in the middle of a division.
    @(negedge clk);
    sm6 = 1'b1; a6 = 6'b100000; b6 = 4'b1111; start6 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start6 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {busy6, done6, q6, r6, dbz6, ovf6}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("rst_after", {busy6, done6, q6, r6, dbz6, ovf6}, 32'd0);

    // Wide instance: 200 / 13.
    sm8 = 1'b0; a8 = 8'd200; b8 = 8'd13; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    lat = 0;
    bcnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bcnt++;
      @(negedge clk);
      lat++;
    end
    chk("w8_q", q8, 8'd15);
    chk("w8_r", r8, 8'd5);
    chk("w8_flags", {dbz8, ovf8}, 2'b00);
    chk("w8_lat", lat, 8);
    chk("w8_busy", bcnt, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Parametrised, iterative restoring divider for the calculator datapath.
- Successor to the 6/4-bit combinational divider array: one quotient bit per clock instead of a ripple of subtractor stages.
- Adds a start/done handshake, a signed mode, divide-by-zero and overflow flags, and result holding.
- Sits between the operand registers and the result mux of the calculator core.

Parameters:
N_WIDTH, 6, dividend and quotient width (>=2)
D_WIDTH, 4, divisor and remainder width (>=2, <=N_WIDTH)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only when not busy
signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; captured with start
dividend  in  N_WIDTH  A operand; captured with start
divisor  in  D_WIDTH  B operand; captured with start
busy  out  1  high while a division is in progress
done  out  1  one-cycle pulse when results become valid
quotient  out  N_WIDTH  S result; held until next accepted start
remainder  out  D_WIDTH  R result; held until next accepted start
div_by_zero  out  1  divisor was 0; held with results
overflow  out  1  signed most-negative / -1; held with results

Behaviour:
- Reset (asynchronous, any state, including mid-division): state IDLE, counter 0. All outputs 0: busy, done, quotient, remainder, div_by_zero, overflow.
- States are IDLE, RUN and DONE. busy = (state==RUN). done = (state==DONE).
- Start acceptance: start is accepted at a clock edge when state is IDLE or DONE. Back-to-back operation is therefore allowed. start during RUN is ignored with no side effects.
- Accept with divisor != 0:
  - Capture operands and mode.
  - In signed mode, convert both operands to unsigned magnitudes (N_WIDTH and D_WIDTH bits) and record the sign of each.
  - Clear the D_WIDTH+1-bit partial remainder.
  - Counter = N_WIDTH. Go to RUN.
- RUN, each edge (restoring step):
  - Shift the partial remainder left by 1 and bring in the dividend MSB.
  - Trial-subtract the divisor magnitude.
  - If the result is non-negative, keep it and shift quotient bit 1; else restore and shift 0.
  - Decrement the counter.
- Final RUN edge (counter==1):
  - Apply sign correction and register the outputs.
  - Quotient is negated if the operand signs differ. Remainder is negated if the dividend is negative, so the remainder sign follows the dividend (truncating division).
  - Go to DONE.
- Latency: with capture edge k, done is high during the cycle after edge k+N_WIDTH (exactly 1 cycle). Quotient and remainder are valid from that cycle on.
- DONE: lasts one cycle, then returns to IDLE, or to RUN/DONE if a start is accepted on that edge. Outputs hold.
- Divide by zero: on acceptance, go straight to DONE (done in the cycle after edge k).
  - quotient = all ones, remainder = 0, div_by_zero = 1, overflow = 0.
  - The unsigned all-ones quotient applies in both modes.
- Overflow: signed mode, dividend = -2^(N_WIDTH-1) and divisor = -1.
  - quotient = -2^(N_WIDTH-1) (wraps), remainder = 0, overflow = 1.
- div_by_zero and overflow are cleared when a new start is accepted. Quotient and remainder are not cleared until the new result is registered.
- Operand inputs may change freely after capture without affecting the result.
- Unsigned mode ignores operand MSBs as sign. The remainder is always < divisor in magnitude.

Test Plan:
- Unsigned: start with 45/7, signed_mode=0 -> done 6 cycles after capture, quotient=6, remainder=3, busy high 6 cycles, flags 0.
- Extremes: 63/1 -> q=63 r=0. Then 5/15 -> q=0 r=5. Issue the second start in the DONE cycle; it must be accepted back-to-back.
- Signed: -27/5 (6'b100101 / 4'b0101) -> q=6'b111011 (-5), r=4'b1110 (-2). Also 27/-5 -> q=-5 r=2.
- Div by zero: 20/0 -> done the cycle after capture, q=6'b111111, r=0, div_by_zero=1. Next start 10/3 -> flag clears, q=3 r=1.
- Overflow: signed -32/-1 -> q=6'b100000, r=0, overflow=1.
- Robustness: start pulse mid-RUN with other operands -> ignored, original result unchanged. rst_n low mid-RUN -> all outputs 0 immediately, IDLE. Repeat the unsigned case with N_WIDTH=8, D_WIDTH=8: 200/13 -> q=15 r=5, done 8 cycles after capture.
